// File: rtl/frame_capture_pkg.sv
// Shared types and helpers for the binarized frame capture block.
package frame_capture_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2
  } state_e;

  // Bit positions inside the sticky error vector
  localparam int ERR_SHORT = 0;
  localparam int ERR_LONG  = 1;
  localparam int ERR_SOF   = 2;
  localparam int ERR_N     = 3;

  // Number of packed BRAM words per video line
  function automatic int words_per_line(input int width, input int pack_w);
    return width / pack_w;
  endfunction

endpackage

// File: rtl/frame_capture_pixel_packer.sv
// Packs single-bit pixels into PACK_W-bit words. Pixel k of a word lands at
// bit k; a flush emits a partial word with the unused upper bits zero.
module frame_capture_pixel_packer #(
  parameter int PACK_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              shift_i,
  input  logic              pix_i,
  input  logic              clear_i,
  input  logic              flush_i,
  output logic              full_o,
  output logic              word_vld_o,
  output logic [PACK_W-1:0] word_o
);

  localparam int CNT_W = (PACK_W > 1) ? $clog2(PACK_W) : 1;

  logic [PACK_W-1:0] pack_q, pack_d, pack_base, merged, word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
  logic              vld_q, vld_d;

  // Merge the incoming pixel and decide whether a word is complete this beat
  always_comb begin
    pack_base = clear_i ? '0 : pack_q;
    cnt_base  = clear_i ? '0 : cnt_q;
    merged    = pack_base;
    merged[cnt_base] = pix_i;
    full_o    = shift_i && ((cnt_base == CNT_W'(PACK_W - 1)) || flush_i);
    pack_d    = pack_base;
    cnt_d     = cnt_base;
    word_d    = word_q;
    vld_d     = 1'b0;
    if (shift_i) begin
      if (full_o) begin
        word_d = merged;
        vld_d  = 1'b1;
        pack_d = '0;
        cnt_d  = '0;
      end else begin
        pack_d = merged;
        cnt_d  = cnt_base + 1'b1;
      end
    end
  end

  // Pack register, fill count and one-cycle output word strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pack_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      pack_q <= pack_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_vld_o = vld_q;
  assign word_o     = word_q;

endmodule

// File: rtl/frame_capture_packed.sv
// Captures one binarized frame from an AXI4-Stream pixel bus into the QR
// decoder's frame BRAM, PACK_W pixels per word, with line-length checking,
// SOF resynchronisation and sticky error flags.
module frame_capture_packed
  import frame_capture_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PIX_BIT = 0,
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter int PACK_W  = 32,
  parameter int ADDR_W  = 12
) (
  input  logic              s00_axis_aclk,
  input  logic              s00_axis_aresetn,
  input  logic              s00_axis_tvalid,
  input  logic              s00_axis_tlast,
  input  logic              s00_axis_tuser,
  input  logic [DATA_W-1:0] s00_axis_tdata,
  output logic              s00_axis_tready,
  input  logic              start_capture,
  input  logic              continuous,
  input  logic              err_clear,
  output logic [ADDR_W-1:0] m00_bram_addr,
  output logic [PACK_W-1:0] m00_bram_data,
  output logic              m00_bram_we,
  output logic              busy,
  output logic              frame_done,
  output logic              err_short_line,
  output logic              err_long_line,
  output logic              err_early_sof
);

  localparam int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int LINE_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int WPL    = words_per_line(WIDTH, PACK_W);

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d, col_eff;
  logic [LINE_W-1:0]  line_q, line_d, line_eff;
  logic [ADDR_W-1:0]  base_q, base_d, base_eff;
  logic [ADDR_W-1:0]  wptr_q, wptr_d, wptr_eff;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               drop_q, drop_d, drop_eff;
  logic               done_q, done_d;
  logic               busy_q;
  logic               tready_q;
  logic [ERR_N-1:0]   err_q, err_set;
  logic               sof, capt, line_end;
  logic               pk_shift, pk_clear, pk_flush, pk_full, pk_vld;
  logic [PACK_W-1:0]  pk_word;
  logic               unused_tdata;

  assign unused_tdata = ^s00_axis_tdata;

  frame_capture_pixel_packer #(
    .PACK_W (PACK_W)
  ) u_packer (
    .clk_i      (s00_axis_aclk),
    .rst_ni     (s00_axis_aresetn),
    .shift_i    (pk_shift),
    .pix_i      (s00_axis_tdata[PIX_BIT]),
    .clear_i    (pk_clear),
    .flush_i    (pk_flush),
    .full_o     (pk_full),
    .word_vld_o (pk_vld),
    .word_o     (pk_word)
  );

  // FSM, column/line tracking and line-length error detection. A SOF beat
  // (first one, or an early one mid-frame) is handled by zeroing the
  // effective position and then treating it as an ordinary pixel (0,0).
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    line_d   = line_q;
    base_d   = base_q;
    drop_d   = drop_q;
    done_d   = 1'b0;
    err_set  = '0;
    sof      = 1'b0;
    capt     = 1'b0;
    line_end = 1'b0;
    pk_shift = 1'b0;
    pk_clear = 1'b0;
    pk_flush = 1'b0;
    col_eff  = col_q;
    line_eff = line_q;
    base_eff = base_q;
    wptr_eff = wptr_q;
    drop_eff = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (start_capture || continuous) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (s00_axis_tvalid && s00_axis_tuser) begin
          sof     = 1'b1;
          capt    = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (s00_axis_tvalid) begin
          capt = 1'b1;
          if (s00_axis_tuser) begin
            sof              = 1'b1;
            err_set[ERR_SOF] = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sof) begin
      col_eff  = '0;
      line_eff = '0;
      base_eff = '0;
      wptr_eff = '0;
      drop_eff = 1'b0;
      pk_clear = 1'b1;
    end

    if (capt) begin
      col_d  = col_eff;
      line_d = line_eff;
      base_d = base_eff;
      drop_d = drop_eff;
      if (drop_eff) begin
        line_end = s00_axis_tlast;
      end else begin
        pk_shift = 1'b1;
        if (s00_axis_tlast) begin
          line_end = 1'b1;
          if (col_eff != COL_W'(WIDTH - 1)) begin
            err_set[ERR_SHORT] = 1'b1;
            pk_flush           = 1'b1;
          end
        end else if (col_eff == COL_W'(WIDTH - 1)) begin
          err_set[ERR_LONG] = 1'b1;
          drop_d            = 1'b1;
          col_d             = '0;
        end else begin
          col_d = col_eff + 1'b1;
        end
      end
      if (line_end) begin
        col_d  = '0;
        drop_d = 1'b0;
        base_d = base_eff + ADDR_W'(WPL);
        if (line_eff == LINE_W'(HEIGHT - 1)) begin
          line_d  = '0;
          done_d  = 1'b1;
          state_d = continuous ? ST_WAIT_SOF : ST_IDLE;
        end else begin
          line_d = line_eff + 1'b1;
        end
      end
    end
  end

  // Word address generation: latch the address of each completed word and
  // realign the write pointer to the next line start on every line end.
  always_comb begin
    addr_d = addr_q;
    wptr_d = wptr_eff;
    if (pk_full) begin
      addr_d = wptr_eff;
      wptr_d = wptr_eff + 1'b1;
    end
    if (line_end) wptr_d = base_eff + ADDR_W'(WPL);
  end

  // Control, counter, address and error state registers
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q  <= ST_WAIT_SOF;
      col_q    <= '0;
      line_q   <= '0;
      base_q   <= '0;
      wptr_q   <= '0;
      addr_q   <= '0;
      drop_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      tready_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      line_q   <= line_d;
      base_q   <= base_d;
      wptr_q   <= wptr_d;
      addr_q   <= addr_d;
      drop_q   <= drop_d;
      done_q   <= done_d;
      busy_q   <= (state_d != ST_IDLE);
      tready_q <= 1'b1;
      err_q    <= (err_q & ~{ERR_N{err_clear}}) | err_set;
    end
  end

  assign s00_axis_tready = tready_q;
  assign m00_bram_addr   = addr_q;
  assign m00_bram_data   = pk_word;
  assign m00_bram_we     = pk_vld;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign err_short_line  = err_q[ERR_SHORT];
  assign err_long_line   = err_q[ERR_LONG];
  assign err_early_sof   = err_q[ERR_SOF];

endmodule

// File: tb/tb_frame_capture_packed.sv
// Directed testbench for frame_capture_packed with an 8x2 frame, 4 pixels/word.
module tb_frame_capture_packed;

  localparam int DATA_W  = 8;
  localparam int PIX_BIT = 0;
  localparam int WIDTH   = 8;
  localparam int HEIGHT  = 2;
  localparam int PACK_W  = 4;
  localparam int ADDR_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic [DATA_W-1:0] tdata = '0;
  logic              tready;
  logic              start = 1'b0, cont = 1'b0, eclr = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic [PACK_W-1:0] data;
  logic              we, busy, done, e_s, e_l, e_e;

  frame_capture_packed #(
    .DATA_W(DATA_W), .PIX_BIT(PIX_BIT), .WIDTH(WIDTH),
    .HEIGHT(HEIGHT), .PACK_W(PACK_W), .ADDR_W(ADDR_W)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (tvalid),
    .s00_axis_tlast   (tlast),
    .s00_axis_tuser   (tuser),
    .s00_axis_tdata   (tdata),
    .s00_axis_tready  (tready),
    .start_capture    (start),
    .continuous       (cont),
    .err_clear        (eclr),
    .m00_bram_addr    (addr),
    .m00_bram_data    (data),
    .m00_bram_we      (we),
    .busy             (busy),
    .frame_done       (done),
    .err_short_line   (e_s),
    .err_long_line    (e_l),
    .err_early_sof    (e_e)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ndone = 0;
  int done_cyc = -1;
  int idle_cnt = 0;
  int last_cyc = 0;
  bit mon_busy = 1'b0;
  logic [ADDR_W-1:0] wa[$];
  logic [PACK_W-1:0] wd[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write/frame-done logger, sampled mid-cycle
  always @(negedge clk) begin
    if (we) begin
      wa.push_back(addr);
      wd.push_back(data);
    end
    if (done) begin
      ndone    <= ndone + 1;
      done_cyc <= cyc;
    end
    if (mon_busy && !busy) idle_cnt <= idle_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // exp packs (addr,data) pairs: entry k is exp[8k+:8], addr in the high nibble
  task automatic chk_wrs(input string tag, input int b, input int n, input logic [63:0] exp);
    chk({tag, "_nwr"}, wa.size() - b, n);
    for (int k = 0; k < n; k++) begin
      if (b + k < wa.size()) begin
        chk($sformatf("%s_a%0d", tag, k), 32'(wa[b+k]), 32'(exp[8*k+4 +: 4]));
        chk($sformatf("%s_d%0d", tag, k), 32'(wd[b+k]), 32'(exp[8*k +: 4]));
      end
    end
  endtask

  task automatic send(input logic p, input logic u, input logic l);
    tvalid = 1'b1;
    tdata = '0;
    tdata[PIX_BIT] = p;
    tuser = u;
    tlast = l;
    @(posedge clk);
    #1;
    last_cyc = cyc;
    tvalid = 1'b0;
    tuser = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic send_line(input logic [15:0] px, input int n, input bit sof);
    for (int i = 0; i < n; i++) send(px[i], sof && (i == 0), i == n - 1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clear_err();
    eclr = 1'b1;
    @(posedge clk);
    #1;
    eclr = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int wb, db, ib, lc;

    // Reset state
    #2;
    chk("rst_tready", tready, 0);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_errs", {e_s, e_l, e_e}, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tready", tready, 1);
    chk("post_rst_busy", busy, 1);

    // Clean frame captured without arming
    wb = wa.size(); db = ndone;
    send_line(16'h008D, 8, 1'b1);
    send_line(16'h000F, 8, 1'b0);
    lc = last_cyc;
    settle(3);
    chk_wrs("t1", wb, 4, 64'h302F180D);
    chk("t1_ndone", ndone - db, 1);
    chk("t1_done_cyc", done_cyc, lc);
    chk("t1_idle", busy, 0);
    chk("t1_errs", {e_s, e_l, e_e}, 0);

    // Short line 0
    arm();
    chk("t2_armed", busy, 1);
    wb = wa.size(); db = ndone;
    send_line(16'h003F, 6, 1'b1);
    send_line(16'h00E1, 8, 1'b0);
    settle(3);
    chk_wrs("t2", wb, 4, 64'h3E21130F);
    chk("t2_ndone", ndone - db, 1);
    chk("t2_errs", {e_s, e_l, e_e}, 3'b100);
    clear_err();
    chk("t2_clr", {e_s, e_l, e_e}, 0);

    // Long line 0 (10 beats)
    arm();
    wb = wa.size(); db = ndone;
    send_line(16'h033A, 10, 1'b1);
    send_line(16'h0010, 8, 1'b0);
    settle(3);
    chk_wrs("t3", wb, 4, 64'h3120130A);
    chk("t3_ndone", ndone - db, 1);
    chk("t3_errs", {e_s, e_l, e_e}, 3'b010);
    clear_err();

    // Early SOF on pixel 3 of line 1
    arm();
    wb = wa.size(); db = ndone;
    send_line(16'h00FF, 8, 1'b1);
    send(1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    chk("t4_sof_busy", busy, 1);
    for (int j = 0; j < 7; j++) send((j == 3) || (j == 4), 1'b0, j == 6);
    chk("t4_mid_ndone", ndone - db, 0);
    send_line(16'h0096, 8, 1'b0);
    settle(3);
    chk_wrs("t4", wb, 6, 64'h0000392613011F0F);
    chk("t4_ndone", ndone - db, 1);
    chk("t4_errs", {e_s, e_l, e_e}, 3'b001);
    clear_err();

    // Continuous: two back-to-back frames, then drop to IDLE
    cont = 1'b1;
    settle(1);
    wb = wa.size(); db = ndone; ib = idle_cnt;
    mon_busy = 1'b1;
    send_line(16'h008D, 8, 1'b1);
    send_line(16'h000F, 8, 1'b0);
    send_line(16'h00F0, 8, 1'b1);
    cont = 1'b0;
    send_line(16'h0081, 8, 1'b0);
    mon_busy = 1'b0;
    settle(3);
    chk_wrs("t5", wb, 8, 64'h38211F00302F180D);
    chk("t5_ndone", ndone - db, 2);
    chk("t5_no_idle", idle_cnt - ib, 0);
    chk("t5_idle_after", busy, 0);

    // Unarmed frame is ignored; armed one is captured
    wb = wa.size(); db = ndone;
    send_line(16'h00F0, 8, 1'b1);
    send_line(16'h0081, 8, 1'b0);
    settle(3);
    chk("t5u_nwr", wa.size() - wb, 0);
    chk("t5u_ndone", ndone - db, 0);
    arm();
    wb = wa.size(); db = ndone;
    send_line(16'h008D, 8, 1'b1);
    send_line(16'h000F, 8, 1'b0);
    settle(3);
    chk_wrs("t5a", wb, 4, 64'h302F180D);
    chk("t5a_ndone", ndone - db, 1);

    // Reset in the middle of line 1 with a write pending
    arm();
    send_line(16'h00FF, 8, 1'b1);
    for (int j = 0; j < 4; j++) send(1'b1, 1'b0, 1'b0);
    chk("t6_we_pre", we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we_rst", we, 0);
    chk("t6_tready_rst", tready, 0);
    chk("t6_busy_rst", busy, 0);
    settle(1);
    #2 rst_n = 1'b1;
    settle(1);
    chk("t6_busy_rel", busy, 1);
    chk("t6_tready_rel", tready, 1);
    wb = wa.size(); db = ndone;
    send_line(16'h00F0, 8, 1'b1);
    send_line(16'h0081, 8, 1'b0);
    settle(3);
    chk_wrs("t6", wb, 4, 64'h38211F00);
    chk("t6_ndone", ndone - db, 1);
    chk("t6_errs", {e_s, e_l, e_e}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_capture_packed.md
Name: frame_capture_packed

Overview:
- Captures one binarized video frame from an AXI4-Stream pixel bus into a frame BRAM for the QR decoder.
- Packs PACK_W pixels into each BRAM word, sized WIDTH x HEIGHT.
- Adds single-shot/continuous modes, line-length checking with realignment, SOF resynchronisation, a frame-done pulse and sticky error flags.
- Sits between the binarizer stream and the decoder's frame BRAM; the decoder arms each capture.

Parameters:
- DATA_W, 32, stream tdata width.
- PIX_BIT, 0, bit of tdata holding the binarized pixel; must be < DATA_W.
- WIDTH, 320, pixels per line; must be a multiple of PACK_W.
- HEIGHT, 240, lines per frame.
- PACK_W, 32, pixels per BRAM word; also the BRAM data width.
- ADDR_W, 12, BRAM word address width; must be >= clog2(WIDTH*HEIGHT/PACK_W).

Ports:
- s00_axis_aclk  in  1  clock.
- s00_axis_aresetn  in  1  reset, asynchronous, active-low.
- s00_axis_tvalid  in  1  beat valid.
- s00_axis_tlast  in  1  end of line.
- s00_axis_tuser  in  1  start of frame, on the first pixel.
- s00_axis_tdata  in  DATA_W  pixel data.
- s00_axis_tready  out  1  always 1 out of reset; 0 while in reset.
- start_capture  in  1  single-cycle arm request.
- continuous  in  1  1 = re-arm automatically after each frame.
- err_clear  in  1  clears the sticky error flags.
- m00_bram_addr  out  ADDR_W  word address.
- m00_bram_data  out  PACK_W  packed pixels; pixel k of a word sits at bit k.
- m00_bram_we  out  1  write strobe.
- busy  out  1  high in WAIT_SOF and CAPTURE.
- frame_done  out  1  one-cycle pulse.
- err_short_line  out  1  sticky.
- err_long_line  out  1  sticky.
- err_early_sof  out  1  sticky.

Behaviour:
- Reset (async assert, sync release):
  - state = WAIT_SOF, so the first frame after reset is always captured.
  - All outputs, counters and the pack register are 0.
- A beat is "accepted" when tvalid=1. No backpressure is applied. With tvalid=0, nothing changes and we=0.
- IDLE:
  - Transitions to WAIT_SOF on start_capture=1 or continuous=1.
  - we=0.
- WAIT_SOF:
  - Beats are discarded until an accepted beat has tuser=1.
  - That beat is pixel (0,0): col=0, line=0, word address 0. Go to CAPTURE.
- CAPTURE:
  - Each accepted beat shifts tdata[PIX_BIT] into pack bit col mod PACK_W, then col increments.
  - When col mod PACK_W = PACK_W-1, the following cycle drives we=1, addr = line*(WIDTH/PACK_W) + col/PACK_W, and the completed word.
  - Write latency is exactly 1 cycle after the word's last beat. we is high for one cycle per word.
- Line end, normal: tlast on col=WIDTH-1. line increments and col is set to 0.
- Line end, short (tlast with col < WIDTH-1):
  - Set err_short_line.
  - If the partial word holds pixels, write it zero-padded at its address on the next cycle.
  - Remaining words of that line are not written.
  - col=0 and line increments, realigning to the next line start.
- Line end, long (col=WIDTH-1 with no tlast):
  - Set err_long_line.
  - Drop further beats until tlast; that tlast ends the line. Dropped beats write nothing.
- tuser=1 on any accepted beat in CAPTURE other than pixel (0,0):
  - Set err_early_sof.
  - The beat becomes the new pixel (0,0). The pack register is cleared; a pending write from the previous cycle still completes.
- Frame end: the line increment out of line HEIGHT-1.
  - frame_done pulses in the same cycle as the final we, or on the cycle after the end beat if there is no pending word.
  - Next state is WAIT_SOF if continuous=1, else IDLE.
- start_capture outside IDLE is ignored.
- err_clear clears all flags. If err_clear and a new error coincide, the set wins.
- The pack counter uses clog2(PACK_W) bits; col, line and addr counters are sized from the parameters, with no wrap-around beyond the frame.
- Asserting reset mid-capture abandons the frame immediately; we deasserts asynchronously.

Decomposition:
- frame_capture_pkg holds:
  - the state enum {IDLE, WAIT_SOF, CAPTURE};
  - the error index constants;
  - a words_per_line function.
- Sub-module pixel_packer (shift/pack register, count, zero-pad flush, word-ready strobe) is instantiated once. The FSM, counters and address generator stay in the top level.

Test Plan (WIDTH=8, HEIGHT=2, PACK_W=4, PIX_BIT=0):
- Reset then a clean frame with pixels 1,0,1,1,0,0,0,1 / 1,1,1,1,0,0,0,0 -> four writes, addr 0..3, data 0xD, 0x8, 0xF, 0x0; frame_done one cycle after the last beat; state IDLE; no errors.
- Line 0 tlast at pixel 5 (1,1,1,1,1,1) -> err_short_line; writes addr0=0xF and addr1=0x3; line 1 lands at addr 2..3.
- Line 0 has 10 beats with tlast on the 10th -> err_long_line; beats 9-10 are not written; line 1 is correct at addr 2..3.
- tuser reasserted on pixel 3 of line 1 -> err_early_sof; capture restarts at addr 0; the frame completes after two further full lines.
- continuous=1 with two back-to-back frames -> two frame_done pulses and no IDLE cycle. continuous=0 with a second frame not armed -> no writes until start_capture.
- Reset asserted mid-line 1 -> we=0 immediately; after release, the state is WAIT_SOF and the next SOF frame is captured from addr 0.
